// File: rtl/appr_mult_pkg.sv
// Shared state encoding and width helpers for the approximate-multiplier error sweep.
// Optional feature macro: APPR_SWEEP_SQERR_EN (squared-error accumulator).
package appr_mult_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Product width (also the pair-counter width)
  function automatic int unsigned prod_w(input int unsigned n);
    return 2 * n;
  endfunction

  // Mismatch counter width: must hold 2^(2N)
  function automatic int unsigned cnt_w(input int unsigned n);
    return 2 * n + 1;
  endfunction

  // Sum of absolute errors over the whole sweep
  function automatic int unsigned sum_w(input int unsigned n);
    return 4 * n;
  endfunction

  // Sum of squared errors over the whole sweep
  function automatic int unsigned sq_w(input int unsigned n);
    return 6 * n;
  endfunction

endpackage

// File: rtl/appr_err_acc.sv
// Registered compare stage: error distance between exact and approximate
// products, accumulated into mismatch count, error sum, max error and
// (with APPR_SWEEP_SQERR_EN) sum of squared errors.
module appr_err_acc
  import appr_mult_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear_i,
  input  logic                   valid_i,
  input  logic [prod_w(N)-1:0]   exact_i,
  input  logic [prod_w(N)-1:0]   appr_i,
  output logic                   pend_o,
  output logic [cnt_w(N)-1:0]    err_cnt_o,
  output logic [sum_w(N)-1:0]    sum_ed_o,
  output logic [prod_w(N)-1:0]   max_ed_o
`ifdef APPR_SWEEP_SQERR_EN
  ,
  output logic [sq_w(N)-1:0]     sum_sq_ed_o
`endif
);

  localparam int unsigned P_W   = prod_w(N);
  localparam int unsigned CNT_W = cnt_w(N);
  localparam int unsigned SUM_W = sum_w(N);
`ifdef APPR_SWEEP_SQERR_EN
  localparam int unsigned SQ_W  = sq_w(N);
  localparam int unsigned SQP_W = 2 * P_W;
`endif

  logic [P_W:0]     diff_c;
  logic [P_W-1:0]   ed_c;
  logic             mis_c;

  logic             pend_q, pend_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic [SUM_W-1:0] sum_q, sum_d;
  logic [P_W-1:0]   max_q, max_d;
`ifdef APPR_SWEEP_SQERR_EN
  logic [SQP_W-1:0] sq_c;
  logic [SQ_W-1:0]  sq_q, sq_d;
`endif

  // Signed difference in P_W+1 bits; its magnitude always fits P_W bits
  assign diff_c = {1'b0, appr_i} - {1'b0, exact_i};
  assign ed_c   = diff_c[P_W] ? P_W'(-diff_c) : diff_c[P_W-1:0];
  assign mis_c  = (appr_i != exact_i);
`ifdef APPR_SWEEP_SQERR_EN
  assign sq_c   = SQP_W'(ed_c) * SQP_W'(ed_c);
`endif

  // Next-state of the accumulators: clear on sweep start, else fold in one pair
  always_comb begin
    pend_d = valid_i;
    err_d  = err_q;
    sum_d  = sum_q;
    max_d  = max_q;
`ifdef APPR_SWEEP_SQERR_EN
    sq_d   = sq_q;
`endif
    if (clear_i) begin
      pend_d = 1'b0;
      err_d  = '0;
      sum_d  = '0;
      max_d  = '0;
`ifdef APPR_SWEEP_SQERR_EN
      sq_d   = '0;
`endif
    end else if (valid_i) begin
      if (mis_c) begin
        err_d = err_q + CNT_W'(1);
      end
      sum_d = sum_q + SUM_W'(ed_c);
      if (ed_c > max_q) begin
        max_d = ed_c;
      end
`ifdef APPR_SWEEP_SQERR_EN
      sq_d = sq_q + SQ_W'(sq_c);
`endif
    end
  end

  // Accumulator registers
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q <= 1'b0;
      err_q  <= '0;
      sum_q  <= '0;
      max_q  <= '0;
`ifdef APPR_SWEEP_SQERR_EN
      sq_q   <= '0;
`endif
    end else begin
      pend_q <= pend_d;
      err_q  <= err_d;
      sum_q  <= sum_d;
      max_q  <= max_d;
`ifdef APPR_SWEEP_SQERR_EN
      sq_q   <= sq_d;
`endif
    end
  end

  assign pend_o    = pend_q;
  assign err_cnt_o = err_q;
  assign sum_ed_o  = sum_q;
  assign max_ed_o  = max_q;
`ifdef APPR_SWEEP_SQERR_EN
  assign sum_sq_ed_o = sq_q;
`endif

endmodule

// File: rtl/appr_mult_err_sweep.sv
// Exhaustive error-characterisation sweep for an external N-bit approximate
// multiplier: issues every (a,b) pair, delays the exact product to line up
// with the multiplier result, and accumulates error metrics on-chip.
// Optional feature macro: APPR_SWEEP_SQERR_EN adds the sum_sq_ed output.
module appr_mult_err_sweep
  import appr_mult_pkg::*;
#(
  parameter int unsigned N       = 4,
  parameter int unsigned MUL_LAT = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic [N-1:0]          op_a,
  output logic [N-1:0]          op_b,
  output logic                  op_valid,
  input  logic [prod_w(N)-1:0]  appr_prod,
  output logic                  busy,
  output logic                  done,
  output logic [cnt_w(N)-1:0]   err_cnt,
  output logic [sum_w(N)-1:0]   sum_ed,
  output logic [prod_w(N)-1:0]  max_ed
`ifdef APPR_SWEEP_SQERR_EN
  ,
  output logic [sq_w(N)-1:0]    sum_sq_ed
`endif
);

  localparam int unsigned P_W = prod_w(N);

  logic [1:0]     state_q, state_d;
  logic [P_W-1:0] cnt_q, cnt_d;
  logic           op_valid_q, op_valid_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;

  logic           last_c;
  logic           accept_c;
  logic [P_W-1:0] exact_c;
  logic           dly_vld_c;
  logic [P_W-1:0] dly_exact_c;
  logic           pipe_fill_c;
  logic           acc_pend_c;

  assign accept_c = (state_q == ST_IDLE) && start;
  assign last_c   = (cnt_q == {P_W{1'b1}});
  assign exact_c  = P_W'(cnt_q[P_W-1:N]) * P_W'(cnt_q[N-1:0]);

  // Exact product and its valid delayed to meet the multiplier's result
  if (MUL_LAT == 0) begin : g_no_lat
    assign dly_vld_c   = op_valid_q;
    assign dly_exact_c = exact_c;
    assign pipe_fill_c = 1'b0;
  end else begin : g_lat
    logic [MUL_LAT-1:0]          vld_q;
    logic [MUL_LAT-1:0][P_W-1:0] exact_q;

    // Shift register: stage 0 takes the issued pair, top stage feeds the compare
    always_ff @(posedge clk) begin
      if (rst) begin
        vld_q   <= '0;
        exact_q <= '0;
      end else begin
        vld_q   <= MUL_LAT'({vld_q, op_valid_q});
        exact_q <= (MUL_LAT*P_W)'({exact_q, exact_c});
      end
    end

    assign dly_vld_c   = vld_q[MUL_LAT-1];
    assign dly_exact_c = exact_q[MUL_LAT-1];
    assign pipe_fill_c = |vld_q;
  end

  // Sweep FSM next-state and registered-output decode
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_valid_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_RUN;
          cnt_d      = '0;
          op_valid_d = 1'b1;
        end
      end
      ST_RUN: begin
        if (last_c) begin
          state_d = ST_DRAIN;
        end else begin
          cnt_d      = cnt_q + P_W'(1);
          op_valid_d = 1'b1;
        end
      end
      ST_DRAIN: begin
        // Wait until nothing is left in the delay line or the compare stage
        if (!(pipe_fill_c || dly_vld_c || acc_pend_c)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  // FSM and pair-counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      op_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_valid_q <= op_valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  appr_err_acc #(
    .N (N)
  ) u_acc (
    .clk        (clk),
    .rst        (rst),
    .clear_i    (accept_c),
    .valid_i    (dly_vld_c),
    .exact_i    (dly_exact_c),
    .appr_i     (appr_prod),
    .pend_o     (acc_pend_c),
    .err_cnt_o  (err_cnt),
    .sum_ed_o   (sum_ed),
    .max_ed_o   (max_ed)
`ifdef APPR_SWEEP_SQERR_EN
    ,
    .sum_sq_ed_o(sum_sq_ed)
`endif
  );

  assign op_a     = cnt_q[P_W-1:N];
  assign op_b     = cnt_q[N-1:0];
  assign op_valid = op_valid_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_appr_mult_err_sweep.sv
// Scoreboard bench: two sweep engines (combinational and 2-cycle multiplier
// models) are started together; expected done cycle and metrics are queued
// at start, and per-engine monitors pop and compare on each done pulse.
module tb_appr_mult_err_sweep;

  localparam int unsigned N = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start0, start2;
  logic [1:0] mode;

  logic [3:0]  op_a0, op_b0, op_a2, op_b2;
  logic        op_valid0, op_valid2, busy0, busy2, done0, done2;
  logic [7:0]  appr0, appr2, p1, p2;
  logic [8:0]  err0, err2;
  logic [15:0] sum0, sum2;
  logic [7:0]  max0, max2;
`ifdef APPR_SWEEP_SQERR_EN
  logic [23:0] sq0, sq2;
`endif

  appr_mult_err_sweep #(.N(N), .MUL_LAT(0)) dut0 (
    .clk(clk), .rst(rst), .start(start0),
    .op_a(op_a0), .op_b(op_b0), .op_valid(op_valid0), .appr_prod(appr0),
    .busy(busy0), .done(done0), .err_cnt(err0), .sum_ed(sum0), .max_ed(max0)
`ifdef APPR_SWEEP_SQERR_EN
    , .sum_sq_ed(sq0)
`endif
  );

  appr_mult_err_sweep #(.N(N), .MUL_LAT(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2),
    .op_a(op_a2), .op_b(op_b2), .op_valid(op_valid2), .appr_prod(appr2),
    .busy(busy2), .done(done2), .err_cnt(err2), .sum_ed(sum2), .max_ed(max2)
`ifdef APPR_SWEEP_SQERR_EN
    , .sum_sq_ed(sq2)
`endif
  );

  // Multipliers under test: 0 exact, 1 LSB cleared, 2 constant zero
  function automatic logic [7:0] model(input logic [1:0] m, input logic [3:0] a, input logic [3:0] b);
    logic [7:0] p;
    p = 8'(a) * 8'(b);
    case (m)
      2'd0:    return p;
      2'd1:    return p & 8'hFE;
      default: return 8'h00;
    endcase
  endfunction

  always_comb appr0 = model(mode, op_a0, op_b0);

  always_ff @(posedge clk) begin
    p1 <= model(mode, op_a2, op_b2);
    p2 <= p1;
  end
  assign appr2 = p2;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int ntot = 0;
  int npass = 0;

  typedef struct {
    int     cyc;
    longint err;
    longint sum;
    longint mx;
    longint sq;
    string  tag;
  } exp_t;

  exp_t q0[$];
  exp_t q2[$];
  exp_t e0, e2;

  task automatic chk(input string nm, input longint act, input longint exp_v);
    ntot++;
    if (act == exp_v) npass++;
    else $display("FAIL %s actual=%0d required=%0d", nm, act, exp_v);
  endtask

  // Monitor for the combinational-multiplier engine
  always @(negedge clk) begin
    if (!rst && done0) begin
      if (q0.size() == 0) begin
        ntot++;
        $display("FAIL dut0_spurious_done actual=1 required=0 cycle=%0d", cyc);
      end else begin
        e0 = q0.pop_front();
        chk({e0.tag, "_l0_done_cycle"}, cyc, e0.cyc);
        chk({e0.tag, "_l0_err_cnt"}, err0, e0.err);
        chk({e0.tag, "_l0_sum_ed"}, sum0, e0.sum);
        chk({e0.tag, "_l0_max_ed"}, max0, e0.mx);
`ifdef APPR_SWEEP_SQERR_EN
        chk({e0.tag, "_l0_sum_sq_ed"}, sq0, e0.sq);
`endif
      end
    end
  end

  // Monitor for the 2-cycle-multiplier engine
  always @(negedge clk) begin
    if (!rst && done2) begin
      if (q2.size() == 0) begin
        ntot++;
        $display("FAIL dut2_spurious_done actual=1 required=0 cycle=%0d", cyc);
      end else begin
        e2 = q2.pop_front();
        chk({e2.tag, "_l2_done_cycle"}, cyc, e2.cyc);
        chk({e2.tag, "_l2_err_cnt"}, err2, e2.err);
        chk({e2.tag, "_l2_sum_ed"}, sum2, e2.sum);
        chk({e2.tag, "_l2_max_ed"}, max2, e2.mx);
`ifdef APPR_SWEEP_SQERR_EN
        chk({e2.tag, "_l2_sum_sq_ed"}, sq2, e2.sq);
`endif
      end
    end
  end

  task automatic chk_reset(input string tag);
    chk({tag, "_op_a0"}, op_a0, 0);
    chk({tag, "_op_b0"}, op_b0, 0);
    chk({tag, "_op_valid0"}, op_valid0, 0);
    chk({tag, "_busy0"}, busy0, 0);
    chk({tag, "_done0"}, done0, 0);
    chk({tag, "_err0"}, err0, 0);
    chk({tag, "_sum0"}, sum0, 0);
    chk({tag, "_max0"}, max0, 0);
    chk({tag, "_op_a2"}, op_a2, 0);
    chk({tag, "_op_valid2"}, op_valid2, 0);
    chk({tag, "_busy2"}, busy2, 0);
    chk({tag, "_err2"}, err2, 0);
    chk({tag, "_sum2"}, sum2, 0);
    chk({tag, "_max2"}, max2, 0);
`ifdef APPR_SWEEP_SQERR_EN
    chk({tag, "_sq0"}, sq0, 0);
    chk({tag, "_sq2"}, sq2, 0);
`endif
  endtask

  // Start both engines together and queue their expected results
  task automatic issue(input logic [1:0] m, input string tag, input longint err,
                       input longint sum, input longint mx, input longint sq);
    exp_t e;
    mode = m;
    @(negedge clk);
    start0 = 1'b1;
    start2 = 1'b1;
    @(posedge clk);
    #1;
    start0 = 1'b0;
    start2 = 1'b0;
    e = '{cyc + 258, err, sum, mx, sq, tag};
    q0.push_back(e);
    e.cyc = cyc + 260;
    q2.push_back(e);
    chk({tag, "_busy0_after_start"}, busy0, 1);
    chk({tag, "_busy2_after_start"}, busy2, 1);
    chk({tag, "_op_valid0_first"}, op_valid0, 1);
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n;
    n = 0;
    while ((q0.size() != 0 || q2.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (q0.size() != 0 || q2.size() != 0) begin
      ntot++;
      $display("FAIL %s_timeout pending0=%0d pending2=%0d required=0", tag, q0.size(), q2.size());
      q0.delete();
      q2.delete();
    end
    @(negedge clk);
  endtask

  task automatic wait_done(input string tag, input bit which2, input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while (!(which2 ? done2 : done0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!(which2 ? done2 : done0)) begin
      ntot++;
      $display("FAIL %s_done_timeout actual=0 required=1", tag);
    end
  endtask

  initial begin
    int n;
    rst    = 1'b1;
    start0 = 1'b0;
    start2 = 1'b0;
    mode   = 2'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset("por");
    rst = 1'b0;

    issue(2'd0, "exact", 0, 0, 0, 0);
    wait_drain("exact", 400);
    issue(2'd1, "lsb", 64, 64, 1, 64);
    wait_drain("lsb", 400);
    issue(2'd2, "zero", 225, 14400, 225, 1537600);
    wait_drain("zero", 400);

    // Metrics and last operand pair hold while idle
    repeat (5) @(negedge clk);
    chk("hold_err0", err0, 225);
    chk("hold_sum2", sum2, 14400);
    chk("hold_max0", max0, 225);
    chk("hold_busy0", busy0, 0);
    chk("hold_op_valid2", op_valid2, 0);
    chk("hold_op_a0", op_a0, 15);
    chk("hold_op_b2", op_b2, 15);

    // Abort mid-sweep at pair 100
    issue(2'd2, "aborted", 225, 14400, 225, 1537600);
    n = 0;
    while (!(op_a0 == 4'd6 && op_b0 == 4'd4) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("abort_reached_pair100", {op_a0, op_b0}, 100);
    chk("abort_partial_sum0_nonzero", (sum0 != 0), 1);
    rst = 1'b1;
    q0.delete();
    q2.delete();
    @(posedge clk);
    #1;
    chk_reset("midrst");
    @(negedge clk);
    rst = 1'b0;
    issue(2'd2, "rerun", 225, 14400, 225, 1537600);
    wait_drain("rerun", 400);

    // start pulses while busy and in the DONE cycle are ignored
    issue(2'd1, "ign", 64, 64, 1, 64);
    repeat (50) @(negedge clk);
    start0 = 1'b1;
    start2 = 1'b1;
    @(posedge clk);
    #1;
    start0 = 1'b0;
    start2 = 1'b0;
    wait_done("ign0", 1'b0, 400);
    start0 = 1'b1;
    @(posedge clk);
    #1;
    start0 = 1'b0;
    wait_done("ign2", 1'b1, 20);
    start2 = 1'b1;
    @(posedge clk);
    #1;
    start2 = 1'b0;
    repeat (30) @(negedge clk);
    chk("ign_busy0", busy0, 0);
    chk("ign_busy2", busy2, 0);
    chk("ign_err0", err0, 64);
    chk("ign_sum2", sum2, 64);
    chk("ign_max2", max2, 1);
    chk("ign_q0_left", q0.size(), 0);
    chk("ign_q2_left", q2.size(), 0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
